// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: per input sample, streams NTAPS (x[n-k], coef[k]) pairs
// over two independently handshaked output channels.
module fir_tap_sequencer #(
    parameter int DW = 24,
    parameter int CW = 18,
    parameter int NTAPS = 8,
    localparam int AW = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          coef_wr_en,
    input  logic [AW-1:0] coef_wr_addr,
    input  logic [CW-1:0] coef_wr_data,
    output logic [DW-1:0] m_axis_atdata,
    output logic          m_axis_atvalid,
    input  logic          m_axis_atready,
    output logic          m_axis_atlast,
    output logic [CW-1:0] m_axis_btdata,
    output logic          m_axis_btvalid,
    input  logic          m_axis_btready
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [AW:0] NT = (AW + 1)'(NTAPS);
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
    state_t state, state_n;
    logic [DW-1:0] hist [NTAPS];
    logic [CW-1:0] coef [NTAPS];
    logic [AW-1:0] wp, rp, k, k_n, rp_n;
    logic a_done, b_done;
    logic s_hs, a_hs, b_hs, pair_done, wr_ok;
    logic [CW-1:0] coef_n;
    assign s_axis_tready = state == IDLE;
    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign a_hs = m_axis_atvalid && m_axis_atready;
    assign b_hs = m_axis_btvalid && m_axis_btready;
    assign pair_done = state == RUN && (a_done || a_hs) && (b_done || b_hs);
    assign wr_ok = coef_wr_en && ({1'b0, coef_wr_addr} < NT);
    assign k_n = s_hs ? '0 : k + AW'(1);
    assign rp_n = rp == '0 ? LAST : rp - AW'(1);
    // A write landing on the same edge that captures its index must be seen
    assign coef_n = (wr_ok && coef_wr_addr == k_n) ? coef_wr_data : coef[k_n];
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = s_hs ? RUN : IDLE;
        else
            state_n = (pair_done && k == LAST) ? IDLE : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
            wp <= '0;
            rp <= '0;
            k <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            m_axis_atdata <= '0;
            m_axis_btdata <= '0;
            m_axis_atlast <= 1'b0;
            m_axis_atvalid <= 1'b0;
            m_axis_btvalid <= 1'b0;
        end else begin
            if (wr_ok)
                coef[coef_wr_addr] <= coef_wr_data;
            if (s_hs) begin
                hist[wp] <= s_axis_tdata;
                wp <= wp == LAST ? '0 : wp + AW'(1);
                rp <= wp;
                k <= '0;
                a_done <= 1'b0;
                b_done <= 1'b0;
                m_axis_atdata <= s_axis_tdata;
                m_axis_btdata <= coef_n;
                m_axis_atlast <= k_n == LAST;
                m_axis_atvalid <= 1'b1;
                m_axis_btvalid <= 1'b1;
            end else if (pair_done) begin
                a_done <= 1'b0;
                b_done <= 1'b0;
                if (k == LAST) begin
                    k <= '0;
                    m_axis_atlast <= 1'b0;
                    m_axis_atvalid <= 1'b0;
                    m_axis_btvalid <= 1'b0;
                end else begin
                    k <= k_n;
                    rp <= rp_n;
                    m_axis_atdata <= hist[rp_n];
                    m_axis_btdata <= coef_n;
                    m_axis_atlast <= k_n == LAST;
                    m_axis_atvalid <= 1'b1;
                    m_axis_btvalid <= 1'b1;
                end
            end else if (state == RUN) begin
                a_done <= a_done || a_hs;
                b_done <= b_done || b_hs;
                if (a_hs)
                    m_axis_atvalid <= 1'b0;
                if (b_hs)
                    m_axis_btvalid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 Parameter DW, default 24: sample width, signed.
REQ-002 Parameter CW, default 18: coefficient width, signed.
REQ-003 Parameter NTAPS, default 8: taps per frame, >=2; AW = $clog2(NTAPS).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 s_axis_tdata/tvalid/tready  in/in/out  DW/1/1  input sample stream.
REQ-007 coef_wr_en/coef_wr_addr/coef_wr_data  in/in/in  1/AW/CW  coefficient write port; no handshake.
REQ-008 m_axis_atdata/atvalid/atready/atlast  out/out/in/out  DW/1/1/1  tap-sample stream; atlast marks the end of frame.
REQ-009 m_axis_btdata/btvalid/btready  out/out/in  CW/1/1  coefficient stream, paired 1:1 with A.

Function
REQ-010 The block SHALL hold an NTAPS-deep sample history (ring buffer, write pointer wraps NTAPS-1 -> 0) and an NTAPS-entry coefficient register file.
REQ-011 The FSM SHALL have two states: IDLE (s_axis_tready=1, no output valid) and RUN (s_axis_tready=0, emitting taps).
REQ-012 IDLE->RUN SHALL occur on the s_axis handshake: sample written at the write pointer, pointer advanced, tap index k=0.
REQ-013 The first tap pair SHALL be valid the cycle after the input handshake; atvalid and btvalid SHALL rise together.
REQ-014 Tap k SHALL present atdata = x[n-k], where x[n] is the newest sample; btdata = coef[k]; atlast = (k==NTAPS-1).
REQ-015 Output data/last SHALL be registered and stable while the corresponding valid is high and unaccepted; valid SHALL NOT depend on ready.
REQ-016 A and B SHALL handshake independently: a per-channel done flag is set on the channel's handshake, and that channel's valid drops until the pair completes; no beat is ever repeated.
REQ-017 The pair SHALL complete when both channels are done or handshaking this cycle; k then advances and next pair is presented the following cycle (both valids high again).
REQ-018 Completion of pair k=NTAPS-1 SHALL return the FSM to IDLE; done flags clear; throughput with both sinks always ready = NTAPS+1 cycles per input sample.
REQ-019 A coefficient write SHALL update coef[coef_wr_addr] at the next edge; a pair already presented keeps its captured btdata; writes take effect on the next presentation of that index.
REQ-020 coef_wr_addr >= NTAPS SHALL be ignored.
REQ-021 Coefficient writes SHALL be accepted in any state, including the cycle of a pair completion.
REQ-022 History entries never written since reset SHALL read as 0.

Reset
REQ-023 On rst_n low, asynchronously: FSM=IDLE, s_axis_tready=1 after release, atvalid=btvalid=0, atlast=0, atdata=btdata=0, k=0, done flags=0, write pointer=0, all history=0, all coefficients=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no further output beats; the first post-reset frame starts at k=0.

Verification (NTAPS=4, DW=24, CW=18)
REQ-025 coef={1,2,3,4}; send x=10, sinks always ready -> A=10,0,0,0, B=1,2,3,4, atlast on 4th beat only, first beat 1 cycle after input handshake.
REQ-026 Send x=10,20,30,40,50 back-to-back -> 5th frame A=50,40,30,20 (ring wrap), tready high exactly 1 cycle in every 5.
REQ-027 btready held low 3 cycles with atready=1 on tap 0 -> A beat 0 accepted once, atvalid low until B accepted, no duplicate, tap 1 then presented on both.
REQ-028 Random independent atready/btready backpressure, 100 samples -> A/B beat counts equal, sequence matches golden x[n-k]/coef[k], data stable under stall.
REQ-029 Write coef[2]=-7 while tap 1 is presented -> tap 2 of the current frame carries btdata=-7; a write to index 1 in that cycle is not seen until next frame.
REQ-030 rst_n low during tap 2 -> valids drop immediately; after release A history is all 0, coef all 0, a new x=5 yields A=5,0,0,0.
